gpr_wb_arbiter: RTL and testbench

- Write-side producer for the general-purpose register file.
- Collects writeback results from two sources: the execute unit (EXU) and the load/store unit (LSU).
- Buffers each source in a small FIFO and arbitrates round-robin. Drives the register file's single write port (wen/waddr/wdata) at one write per cycle.
- Keeps a per-register busy scoreboard that issue logic sets and writeback clears.

---
 rtl/gpr_wb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// Register-file write-side producer: buffers EXU and LSU writeback results,
// arbitrates them round-robin onto the single write port, and tracks pending writes.

module gpr_wb_fifo #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic [4:0]  push_rd,
   input  logic [31:0] push_data,
   output logic [4:0]  head_rd,
   output logic [31:0] head_data,
   output logic        not_full,
   output logic        not_empty
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

   logic [4:0]       rd_mem   [FIFO_DEPTH];
   logic [31:0]      data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;

   // Depth is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + PTR_W'(1);
         if (pop)
            rptr <= rptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         rd_mem[wptr]   <= push_rd;
         data_mem[wptr] <= push_data;
      end
   end

   assign head_rd   = rd_mem[rptr];
   assign head_data = data_mem[rptr];
   assign not_full  = (count != FULL_COUNT);
   assign not_empty = (count != '0);

endmodule

module gpr_wb_arbiter #(
   parameter int NR_REG     = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              exu_valid,
   output logic              exu_ready,
   input  logic [4:0]        exu_rd,
   input  logic [31:0]       exu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [4:0]        lsu_rd,
   input  logic [31:0]       lsu_data,
   output logic              gpr_wen,
   output logic [4:0]        gpr_waddr,
   output logic [31:0]       gpr_wdata,
   input  logic              busy_set,
   input  logic [4:0]        busy_rd,
   output logic [NR_REG-1:0] busy
);

   localparam logic [5:0] REG_LIMIT = 6'(NR_REG);

   typedef enum logic {
      SRC_EXU = 1'b0,
      SRC_LSU = 1'b1
   } src_t;

   src_t              last_grant;
   logic              exu_push, lsu_push;
   logic              exu_not_full, lsu_not_full;
   logic              exu_not_empty, lsu_not_empty;
   logic [4:0]        exu_head_rd, lsu_head_rd;
   logic [31:0]       exu_head_data, lsu_head_data;
   logic              grant_exu, grant_lsu, any_grant;
   logic [4:0]        sel_rd;
   logic [31:0]       sel_data;
   logic              sel_writes;
   logic [NR_REG-1:0] busy_next;

   // Ready is held low during reset and never looks at valid.
   assign exu_ready = reset & exu_not_full;
   assign lsu_ready = reset & lsu_not_full;
   assign exu_push  = exu_valid & exu_ready;
   assign lsu_push  = lsu_valid & lsu_ready;

   gpr_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_exu_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (exu_push),
      .pop       (grant_exu),
      .push_rd   (exu_rd),
      .push_data (exu_data),
      .head_rd   (exu_head_rd),
      .head_data (exu_head_data),
      .not_full  (exu_not_full),
      .not_empty (exu_not_empty)
   );

   gpr_wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_lsu_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (lsu_push),
      .pop       (grant_lsu),
      .push_rd   (lsu_rd),
      .push_data (lsu_data),
      .head_rd   (lsu_head_rd),
      .head_data (lsu_head_data),
      .not_full  (lsu_not_full),
      .not_empty (lsu_not_empty)
   );

   always_comb begin
      grant_exu = 1'b0;
      grant_lsu = 1'b0;
      if (exu_not_empty && lsu_not_empty) begin
         if (last_grant == SRC_LSU)
            grant_exu = 1'b1;
         else
            grant_lsu = 1'b1;
      end else if (exu_not_empty) begin
         grant_exu = 1'b1;
      end else if (lsu_not_empty) begin
         grant_lsu = 1'b1;
      end
   end

   assign any_grant  = grant_exu | grant_lsu;
   assign sel_rd     = grant_lsu ? lsu_head_rd : exu_head_rd;
   assign sel_data   = grant_lsu ? lsu_head_data : exu_head_data;
   assign sel_writes = any_grant & (sel_rd != 5'd0) & ({1'b0, sel_rd} < REG_LIMIT);

   // A new busy_set beats the clear from a writeback to the same register.
   always_comb begin
      busy_next = '0;
      for (int r = 1; r < NR_REG; r++) begin
         if (busy_set && (busy_rd == 5'(r)))
            busy_next[r] = 1'b1;
         else if (sel_writes && (sel_rd == 5'(r)))
            busy_next[r] = 1'b0;
         else
            busy_next[r] = busy[r];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gpr_wen    <= 1'b0;
         gpr_waddr  <= '0;
         gpr_wdata  <= '0;
         busy       <= '0;
         last_grant <= SRC_LSU;
      end else begin
         gpr_wen <= sel_writes;
         busy    <= busy_next;
         if (any_grant) begin
            gpr_waddr  <= sel_rd;
            gpr_wdata  <= sel_data;
            last_grant <= grant_lsu ? SRC_LSU : SRC_EXU;
         end
      end
   end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the writeback path and scoreboard.

module tb_gpr_wb_arbiter;

   localparam int NR_REG = 16;
   localparam int DEPTH  = 2;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              exu_valid, lsu_valid, busy_set;
   logic              exu_ready, lsu_ready, gpr_wen;
   logic [4:0]        exu_rd, lsu_rd, busy_rd, gpr_waddr;
   logic [31:0]       exu_data, lsu_data, gpr_wdata;
   logic [NR_REG-1:0] busy;
   logic [55:0]       act_vec;

   ent_t              exu_q[$];
   ent_t              lsu_q[$];
   bit                m_last_lsu;
   logic              m_wen;
   logic [4:0]        m_waddr;
   logic [31:0]       m_wdata;
   logic [NR_REG-1:0] m_busy;
   bit                m_exu_acc, m_lsu_acc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   gpr_wb_arbiter #(.NR_REG(NR_REG), .FIFO_DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .exu_valid (exu_valid),
      .exu_ready (exu_ready),
      .exu_rd    (exu_rd),
      .exu_data  (exu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .gpr_wen   (gpr_wen),
      .gpr_waddr (gpr_waddr),
      .gpr_wdata (gpr_wdata),
      .busy_set  (busy_set),
      .busy_rd   (busy_rd),
      .busy      (busy)
   );

   assign act_vec = {gpr_wen, gpr_waddr, gpr_wdata, busy, exu_ready, lsu_ready};

   function automatic logic [55:0] exp_vec();
      logic er, lr;
      er = reset && (exu_q.size() != DEPTH);
      lr = reset && (lsu_q.size() != DEPTH);
      return {m_wen, m_waddr, m_wdata, m_busy, er, lr};
   endfunction

   task automatic model_reset();
      exu_q.delete();
      lsu_q.delete();
      m_last_lsu = 1'b1;
      m_wen      = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      m_busy     = '0;
      m_exu_acc  = 1'b0;
      m_lsu_acc  = 1'b0;
   endtask

   // One clock edge of the reference behaviour, from the pre-edge inputs.
   task automatic model_step();
      int   ne, nl, g;
      ent_t e;
      ne = exu_q.size();
      nl = lsu_q.size();
      g  = -1;
      e  = '0;
      if (ne > 0 && nl > 0) g = m_last_lsu ? 0 : 1;
      else if (ne > 0)      g = 0;
      else if (nl > 0)      g = 1;
      m_exu_acc = exu_valid && (ne < DEPTH);
      m_lsu_acc = lsu_valid && (nl < DEPTH);
      if (g == 0) e = exu_q.pop_front();
      if (g == 1) e = lsu_q.pop_front();
      if (m_exu_acc) exu_q.push_back({exu_rd, exu_data});
      if (m_lsu_acc) lsu_q.push_back({lsu_rd, lsu_data});
      if (g >= 0) begin
         m_last_lsu = (g == 1);
         m_wen      = (e.rd != 0) && (e.rd < NR_REG);
         m_waddr    = e.rd;
         m_wdata    = e.data;
         if (m_wen) m_busy[e.rd] = 1'b0;
      end else begin
         m_wen = 1'b0;
      end
      if (busy_set && busy_rd != 0 && busy_rd < NR_REG) m_busy[busy_rd] = 1'b1;
   endtask

   task automatic tick();
      if (!reset) model_reset();
      else        model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      exu_valid = 1'b0;
      lsu_valid = 1'b0;
      busy_set  = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      #1;
      model_reset();
      tick();
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL reset_state: got %h expected %h", act_vec, exp_vec());
      end
      tick();
      n_checks++;
      if (act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL reset_hold: got %h expected %h", act_vec, exp_vec());
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({exu_ready, lsu_ready} !== 2'b11) begin
         n_errors++;
         $display("FAIL reset_release_ready: got %b expected 11", {exu_ready, lsu_ready});
      end
   endtask

   task automatic test_single_write();
      idle();
      exu_valid = 1'b1;
      exu_rd    = 5'd5;
      exu_data  = 32'hDEADBEEF;
      tick();
      exu_valid = 1'b0;
      n_checks++;
      if (gpr_wen !== 1'b0 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL single_c2: got %h expected %h", act_vec, exp_vec());
      end
      tick();
      n_checks++;
      if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         n_errors++;
         $display("FAIL single_c3: got %b/%0d/%h expected 1/5/deadbeef", gpr_wen, gpr_waddr, gpr_wdata);
      end
      tick();
      n_checks++;
      if (gpr_wen !== 1'b0 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL single_c4: got %h expected %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_round_robin();
      logic [4:0] order [4];
      order[0] = 5'd1; order[1] = 5'd3; order[2] = 5'd2; order[3] = 5'd4;
      do_reset();
      exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h1000_0001;
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h1000_0003;
      tick();
      exu_rd = 5'd2; exu_data = 32'h1000_0002;
      lsu_rd = 5'd4; lsu_data = 32'h1000_0004;
      tick();
      idle();
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         n_checks++;
         if ({gpr_wen, gpr_waddr} !== {1'b1, order[k]} || act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL rr_order[%0d]: got wen=%b rd=%0d expected wen=1 rd=%0d", k, gpr_wen, gpr_waddr, order[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] acc[$];
      logic [31:0] obs[$];
      int          ek = 0, lk = 0;
      bit          ok;
      idle();
      exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'hA000_0000;
      lsu_valid = 1'b1; lsu_rd = 5'd1;  lsu_data = 32'hB000_0000;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (m_lsu_acc) acc.push_back(lsu_data);
         if (gpr_wen && gpr_wdata[31:24] == 8'hB0) obs.push_back(gpr_wdata);
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL bp_fill[%0d]: got %h expected %h", c, act_vec, exp_vec());
         end
         if (lsu_q.size() == DEPTH) begin
            n_checks++;
            if (lsu_ready !== 1'b0) begin
               n_errors++;
               $display("FAIL bp_lsu_ready_full: got %b expected 0", lsu_ready);
            end
         end
         if (m_exu_acc) begin
            ek++;
            exu_data = 32'hA000_0000 + 32'(ek);
         end
         if (m_lsu_acc) begin
            lk++;
            lsu_rd   = 5'(1 + (lk % 14));
            lsu_data = 32'hB000_0000 + 32'(lk);
         end
      end
      exu_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (m_lsu_acc) acc.push_back(lsu_data);
         if (m_lsu_acc) lsu_valid = 1'b0;
         if (gpr_wen && gpr_wdata[31:24] == 8'hB0) obs.push_back(gpr_wdata);
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL bp_drain[%0d]: got %h expected %h", c, act_vec, exp_vec());
         end
      end
      ok = (acc.size() == obs.size());
      if (ok) foreach (acc[i]) if (acc[i] !== obs[i]) ok = 0;
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL bp_lsu_order: got %0d writes expected %0d in push order", obs.size(), acc.size());
      end
   endtask

   task automatic test_x0_discard();
      idle();
      for (int c = 0; c < 3; c++) tick();
      exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h0000_1234;
      tick();
      exu_rd = 5'd7; exu_data = 32'h0000_0777;
      tick();
      exu_valid = 1'b0;
      n_checks++;
      if (gpr_wen !== 1'b0 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL x0_no_write: got %h expected %h", act_vec, exp_vec());
      end
      tick();
      n_checks++;
      if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, 5'd7, 32'h0000_0777}) begin
         n_errors++;
         $display("FAIL x0_next_write: got %b/%0d/%h expected 1/7/00000777", gpr_wen, gpr_waddr, gpr_wdata);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      busy_set = 1'b1; busy_rd = 5'd9;
      tick();
      busy_set = 1'b0;
      n_checks++;
      if (busy[9] !== 1'b1 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL sb_set: got %h expected %h", act_vec, exp_vec());
      end
      exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_0099;
      tick();
      exu_valid = 1'b0;
      tick();
      n_checks++;
      if (busy[9] !== 1'b0 || gpr_wen !== 1'b1 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL sb_clear: got %h expected %h", act_vec, exp_vec());
      end
      busy_set = 1'b1; busy_rd = 5'd0;
      tick();
      busy_rd = 5'd20;
      tick();
      busy_set = 1'b0;
      n_checks++;
      if (busy !== '0 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL sb_ignore: got busy %h expected 0000", busy);
      end
      exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_0999;
      tick();
      exu_valid = 1'b0;
      busy_set = 1'b1; busy_rd = 5'd9;
      tick();
      busy_set = 1'b0;
      n_checks++;
      if (busy[9] !== 1'b1 || {gpr_wen, gpr_waddr} !== {1'b1, 5'd9} || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL sb_set_wins: got %h expected %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_reset_mid();
      idle();
      exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hC000_0003;
      lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'hC000_0006;
      busy_set  = 1'b1; busy_rd = 5'd12;
      tick();
      exu_rd = 5'd4; exu_data = 32'hC000_0004;
      lsu_rd = 5'd8; lsu_data = 32'hC000_0008;
      busy_set = 1'b0;
      tick();
      idle();
      reset = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (gpr_wen !== 1'b0 || busy !== '0 || act_vec !== exp_vec()) begin
         n_errors++;
         $display("FAIL mid_reset_async: got %h expected %h", act_vec, exp_vec());
      end
      tick();
      reset = 1'b1;
      #1;
      n_checks++;
      if ({exu_ready, lsu_ready} !== 2'b11) begin
         n_errors++;
         $display("FAIL mid_reset_ready: got %b expected 11", {exu_ready, lsu_ready});
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (gpr_wen !== 1'b0 || act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL mid_reset_nowrite[%0d]: got %h expected %h", c, act_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      idle();
      for (int c = 0; c < 400; c++) begin
         if (!exu_valid || m_exu_acc) begin
            exu_valid = ($urandom_range(0, 3) != 0);
            exu_rd    = 5'($urandom_range(0, 31));
            exu_data  = $urandom;
         end
         if (!lsu_valid || m_lsu_acc) begin
            lsu_valid = ($urandom_range(0, 2) != 0);
            lsu_rd    = 5'($urandom_range(0, 31));
            lsu_data  = $urandom;
         end
         busy_set = ($urandom_range(0, 2) == 0);
         busy_rd  = 5'($urandom_range(0, 31));
         tick();
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL random[%0d]: got %h expected %h", c, act_vec, exp_vec());
         end
      end
      for (int c = 0; c < 20 && (exu_valid || lsu_valid); c++) begin
         if (m_exu_acc) exu_valid = 1'b0;
         if (m_lsu_acc) lsu_valid = 1'b0;
         busy_set = 1'b0;
         tick();
      end
      idle();
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL random_drain[%0d]: got %h expected %h", c, act_vec, exp_vec());
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      busy_set  = 1'b0; busy_rd = '0;
      model_reset();
      #1;
      test_reset();
      test_single_write();
      test_round_robin();
      test_backpressure();
      test_x0_discard();
      test_scoreboard();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
